keypad_digit_buffer: RTL and testbench

- Parametrised multi-digit entry buffer for the keypad/LCD path, successor to the single-mode bit/nibble shift register.
- Holds up to COUNT symbols of WIDTH bits. The newest symbol sits in the least-significant slot.
- Supports push (shift-in), backspace, simultaneous replace, clear and parallel load, with occupancy tracking and overflow handling.
- Drives the LCD digit formatter; fed by the keypad decoder's one-cycle key strobes.

---
 rtl/keypad_digit_buffer.sv | 116 +++++++++++
 tb/tb_keypad_digit_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_buffer.sv
// Multi-digit keypad entry buffer: push/backspace/replace/clear/load with
// occupancy tracking and a selectable full-buffer push policy.
module keypad_digit_buffer #(
  parameter int COUNT    = 4,
  parameter int WIDTH    = 4,
  parameter int OVF_MODE = 0
) (
  input  logic                     trig,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     load,
  input  logic [COUNT*WIDTH-1:0]   load_data,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         in,
  output logic [COUNT*WIDTH-1:0]   out,
  output logic [$clog2(COUNT+1)-1:0] count,
  output logic                     empty,
  output logic                     full,
  output logic                     evict_valid,
  output logic [WIDTH-1:0]         evict_data,
  output logic                     reject
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int DW = COUNT * WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(COUNT);

  logic [DW-1:0]    r_out;
  logic [CW-1:0]    r_count;
  logic             r_evict_valid;
  logic [WIDTH-1:0] r_evict_data;
  logic             r_reject;

  logic [DW-1:0]    w_out_next;
  logic [CW-1:0]    w_count_next;
  logic             w_evict_valid_next;
  logic [WIDTH-1:0] w_evict_data_next;
  logic             w_reject_next;
  logic             w_empty;
  logic             w_full;
  logic [DW-1:0]    w_shift_in;
  logic [DW-1:0]    w_shift_out;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Newest symbol enters slot 0; backspace drops slot 0 and zero-fills the top slot.
  assign w_shift_in  = {r_out[DW-WIDTH-1:0], in};
  assign w_shift_out = {{WIDTH{1'b0}}, r_out[DW-1:WIDTH]};

  always_comb begin
    w_out_next         = r_out;
    w_count_next       = r_count;
    w_evict_valid_next = 1'b0;
    w_evict_data_next  = r_evict_data;
    w_reject_next      = 1'b0;

    if (clr) begin
      w_out_next   = '0;
      w_count_next = '0;
    end else if (load) begin
      w_out_next   = load_data;
      w_count_next = FULL_CNT;
    end else if (push && pop) begin
      // Empty buffer holds all-zero slots, so replacing slot 0 is equivalent to a push.
      w_out_next[WIDTH-1:0] = in;
      if (w_empty) begin
        w_count_next = CW'(1);
      end
    end else if (push) begin
      if (!w_full) begin
        w_out_next   = w_shift_in;
        w_count_next = r_count + CW'(1);
      end else if (OVF_MODE == 0) begin
        w_out_next         = w_shift_in;
        w_evict_valid_next = 1'b1;
        w_evict_data_next  = r_out[DW-1 -: WIDTH];
      end else begin
        w_reject_next = 1'b1;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_reject_next = 1'b1;
      end else begin
        w_out_next   = w_shift_out;
        w_count_next = r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge trig or negedge reset) begin
    if (!reset) begin
      r_out         <= '0;
      r_count       <= '0;
      r_evict_valid <= 1'b0;
      r_evict_data  <= '0;
      r_reject      <= 1'b0;
    end else begin
      r_out         <= w_out_next;
      r_count       <= w_count_next;
      r_evict_valid <= w_evict_valid_next;
      r_evict_data  <= w_evict_data_next;
      r_reject      <= w_reject_next;
    end
  end

  assign out         = r_out;
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign evict_valid = r_evict_valid;
  assign evict_data  = r_evict_data;
  assign reject      = r_reject;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Bench for keypad_digit_buffer: both overflow policies side by side, checked
// against a queue-based model of the digit entry rules.
module tb_keypad_digit_buffer;

  localparam int COUNT = 4;
  localparam int WIDTH = 4;

  logic        trig  = 1'b0;
  logic        reset = 1'b0;
  logic        d_clr, d_load, d_push, d_pop;
  logic [15:0] d_load_data;
  logic [3:0]  d_in;

  logic [15:0] o0_out, o1_out;
  logic [2:0]  o0_count, o1_count;
  logic        o0_empty, o1_empty, o0_full, o1_full;
  logic        o0_ev, o1_ev, o0_rej, o1_rej;
  logic [3:0]  o0_evd, o1_evd;

  int errors = 0;
  int checks = 0;

  // Model: q[0] is the newest symbol; slots past q.size() read as zero.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic       m_ev  [2];
  logic [3:0] m_evd [2];
  logic       m_rej [2];

  always #5 trig = ~trig;

  keypad_digit_buffer #(.COUNT(COUNT), .WIDTH(WIDTH), .OVF_MODE(0)) dut0 (
    .trig(trig), .reset(reset), .clr(d_clr), .load(d_load), .load_data(d_load_data),
    .push(d_push), .pop(d_pop), .in(d_in), .out(o0_out), .count(o0_count),
    .empty(o0_empty), .full(o0_full), .evict_valid(o0_ev), .evict_data(o0_evd),
    .reject(o0_rej)
  );

  keypad_digit_buffer #(.COUNT(COUNT), .WIDTH(WIDTH), .OVF_MODE(1)) dut1 (
    .trig(trig), .reset(reset), .clr(d_clr), .load(d_load), .load_data(d_load_data),
    .push(d_push), .pop(d_pop), .in(d_in), .out(o1_out), .count(o1_count),
    .empty(o1_empty), .full(o1_full), .evict_valid(o1_ev), .evict_data(o1_evd),
    .reject(o1_rej)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      m_ev[m]  = 1'b0;
      m_evd[m] = '0;
      m_rej[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m);
    logic [3:0] q[$];
    if (m == 0) q = q0; else q = q1;
    m_ev[m]  = 1'b0;
    m_rej[m] = 1'b0;
    if (d_clr) begin
      q.delete();
    end else if (d_load) begin
      q.delete();
      for (int k = 0; k < COUNT; k++) q.push_back(d_load_data[k*WIDTH +: WIDTH]);
    end else if (d_push && d_pop) begin
      if (q.size() > 0) q[0] = d_in;
      else q.push_front(d_in);
    end else if (d_push) begin
      if (q.size() < COUNT) begin
        q.push_front(d_in);
      end else if (m == 0) begin
        m_evd[m] = q.pop_back();
        m_ev[m]  = 1'b1;
        q.push_front(d_in);
      end else begin
        m_rej[m] = 1'b1;
      end
    end else if (d_pop) begin
      if (q.size() == 0) m_rej[m] = 1'b1;
      else void'(q.pop_front());
    end
    if (m == 0) q0 = q; else q1 = q;
  endtask

  task automatic check_dut(input int m, input logic [15:0] o, input logic [2:0] c,
                           input logic e, input logic f, input logic ev,
                           input logic [3:0] evd, input logic rj);
    logic [15:0] exp_o;
    int n;
    string p;
    exp_o = '0;
    p = (m == 0) ? "m0" : "m1";
    if (m == 0) begin
      n = q0.size();
      for (int k = 0; k < n; k++) exp_o[k*WIDTH +: WIDTH] = q0[k];
    end else begin
      n = q1.size();
      for (int k = 0; k < n; k++) exp_o[k*WIDTH +: WIDTH] = q1[k];
    end
    chk({p, "_out"},   64'(o),   64'(exp_o));
    chk({p, "_count"}, 64'(c),   64'(n));
    chk({p, "_empty"}, 64'(e),   64'(n == 0));
    chk({p, "_full"},  64'(f),   64'(n == COUNT));
    chk({p, "_evv"},   64'(ev),  64'(m_ev[m]));
    chk({p, "_evd"},   64'(evd), 64'(m_evd[m]));
    chk({p, "_rej"},   64'(rj),  64'(m_rej[m]));
  endtask

  task automatic check_all();
    check_dut(0, o0_out, o0_count, o0_empty, o0_full, o0_ev, o0_evd, o0_rej);
    check_dut(1, o1_out, o1_count, o1_empty, o1_full, o1_ev, o1_evd, o1_rej);
  endtask

  task automatic do_step(input logic c, input logic l, input logic [15:0] ld,
                         input logic p, input logic pp, input logic [3:0] v);
    d_clr = c; d_load = l; d_load_data = ld; d_push = p; d_pop = pp; d_in = v;
    @(posedge trig);
    #1;
    model_step(0);
    model_step(1);
    check_all();
    $display("step clr=%0b load=%0b push=%0b pop=%0b in=%h | m0 out=%h cnt=%0d ev=%0b/%h | m1 out=%h cnt=%0d rej=%0b",
             c, l, p, pp, v, o0_out, o0_count, o0_ev, o0_evd, o1_out, o1_count, o1_rej);
    d_clr = 0; d_load = 0; d_push = 0; d_pop = 0;
  endtask

  initial begin
    d_clr = 0; d_load = 0; d_push = 0; d_pop = 0; d_in = '0; d_load_data = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    @(negedge trig);

    // Reset arriving in the middle of a push sequence, without a clock edge.
    do_step(0, 0, 16'h0, 1, 0, 4'h1);
    do_step(0, 0, 16'h0, 1, 0, 4'h2);
    d_push = 1; d_in = 4'h3;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_out", 64'(o0_out), 64'h0);
    @(posedge trig);
    #1;
    check_all();
    d_push = 0;
    @(negedge trig);
    reset = 1'b1;
    @(negedge trig);

    // Fill, then overflow under both policies.
    do_step(0, 0, 16'h0, 1, 0, 4'h1);
    do_step(0, 0, 16'h0, 1, 0, 4'h2);
    do_step(0, 0, 16'h0, 1, 0, 4'h3);
    do_step(0, 0, 16'h0, 1, 0, 4'h4);
    chk("plan_fill_m0", 64'(o0_out), 64'h1234);
    chk("plan_fill_m1", 64'(o1_out), 64'h1234);
    do_step(0, 0, 16'h0, 1, 0, 4'h5);
    chk("plan_ovf_m0", 64'(o0_out), 64'h2345);
    chk("plan_ovf_evd", 64'(o0_evd), 64'h1);
    chk("plan_rej_m1", 64'(o1_out), 64'h1234);
    do_step(0, 0, 16'h0, 0, 0, 4'h0);

    // Backspace twice, then replace slot 0.
    do_step(0, 0, 16'h0, 0, 1, 4'h0);
    do_step(0, 0, 16'h0, 0, 1, 4'h0);
    chk("plan_pop_m1", 64'(o1_out), 64'h0012);
    do_step(0, 0, 16'h0, 1, 1, 4'h7);
    chk("plan_repl_m1", 64'(o1_out), 64'h0017);

    // Empty-buffer corner cases.
    do_step(1, 0, 16'h0, 0, 0, 4'h0);
    do_step(0, 0, 16'h0, 0, 1, 4'h0);
    do_step(0, 0, 16'h0, 1, 1, 4'h9);
    chk("plan_pp_empty", 64'(o0_out), 64'h0009);

    // Priority and parallel load.
    do_step(1, 1, 16'hABCD, 1, 0, 4'h5);
    do_step(0, 1, 16'hABCD, 0, 0, 4'h0);
    chk("plan_load", 64'(o0_out), 64'hABCD);
    do_step(0, 1, 16'h1357, 1, 1, 4'hE);
    do_step(0, 0, 16'h0, 0, 1, 4'h0);
    do_step(0, 0, 16'h0, 0, 0, 4'h0);

    // Randomised traffic, strobes weighted towards push/pop.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 31);
      do_step(r == 0, r == 1, 16'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
